// File: rtl/pcie_phys_pkg.sv
// Shared symbol constants and scheduler state type for the PCIe PHY transmit path.
// Imported by the symbol scheduler and its SKP interval timer.
package pcie_phys_pkg;

  localparam logic [7:0] K28_5_COM = 8'hBC;
  localparam logic [7:0] K28_0_SKP = 8'h1C;
  localparam logic [7:0] D0_0_IDLE = 8'h00;

  localparam int SKP_OS_LEN      = 4;
  localparam int MAC_FRAME_BYTES = 4;

  typedef enum logic [1:0] {
    DISABLED,
    RUN,
    SKP
  } tx_sched_state_e;

  // An SKP ordered set is one COM followed by SKP symbols.
  function automatic logic [7:0] skp_os_symbol(input logic [1:0] idx);
    return (idx == 2'd0) ? K28_5_COM : K28_0_SKP;
  endfunction

endpackage

// File: rtl/tx_symbol_scheduler_if.sv
// MAC-side frame handshake plus the symbol stream toward the 8b10b encoder.
// The slave modport is the scheduler; the master modport is the MAC/encoder side.
interface tx_symbol_scheduler_if;

  logic [31:0] mac_data_frame_i;
  logic        mac_data_frame_valid_i;
  logic        mac_data_frame_ready_o;
  logic [7:0]  sym_o;
  logic        sym_is_k_o;
  logic        sym_valid_o;
  logic        skp_active_o;

  modport master (
    output mac_data_frame_i,
    output mac_data_frame_valid_i,
    input  mac_data_frame_ready_o,
    input  sym_o,
    input  sym_is_k_o,
    input  sym_valid_o,
    input  skp_active_o
  );

  modport slave (
    input  mac_data_frame_i,
    input  mac_data_frame_valid_i,
    output mac_data_frame_ready_o,
    output sym_o,
    output sym_is_k_o,
    output sym_valid_o,
    output skp_active_o
  );

endinterface

// File: rtl/tx_symbol_scheduler_skp_interval_timer.sv
// Counts RUN symbols and raises a saturating SKP request every SKP_INTERVAL symbols.
// skp_due_o already includes a wrap happening this cycle so the FSM can act on it at once.
module skp_interval_timer
  import pcie_phys_pkg::*;
#(
  parameter int SKP_INTERVAL = 1180,
  parameter int CNT_W        = $clog2(SKP_INTERVAL)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic tick_i,
  input  logic service_i,
  output logic skp_due_o
);

  if (SKP_INTERVAL < 8) begin : g_bad_interval
    $error("SKP_INTERVAL must be at least 8");
  end

  logic [CNT_W-1:0] cnt_q;
  logic             pending_q;
  logic             wrap;

  assign wrap      = tick_i && (cnt_q == CNT_W'(SKP_INTERVAL - 1));
  assign skp_due_o = pending_q || wrap;

  // Servicing wins over a simultaneous wrap: that wrap is the request being serviced.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      pending_q <= 1'b0;
    end else if (clear_i) begin
      cnt_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      if (tick_i) begin
        cnt_q <= wrap ? '0 : cnt_q + CNT_W'(1);
      end
      if (service_i) begin
        pending_q <= 1'b0;
      end else if (wrap) begin
        pending_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_symbol_scheduler.sv
// Serialises 32-bit MAC frames into one 8b10b symbol per clock, filling gaps with idle
// and inserting SKP ordered sets at frame boundaries when the interval timer asks.
module tx_symbol_scheduler
  import pcie_phys_pkg::*;
#(
  parameter int MAC_FRAME_WIDTH = 32,
  parameter int SKP_INTERVAL    = 1180,
  parameter int CNT_W           = $clog2(SKP_INTERVAL)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  tx_symbol_scheduler_if.slave  mac
);

  if (MAC_FRAME_WIDTH != 32) begin : g_bad_width
    $error("MAC_FRAME_WIDTH must be 32");
  end

  localparam logic [1:0] SKP_LAST  = 2'(SKP_OS_LEN - 1);
  localparam logic [1:0] BYTE_LAST = 2'(MAC_FRAME_BYTES - 1);

  tx_sched_state_e state_q, state_d;
  logic [31:0]     hold_q, hold_d;
  logic            hold_full_q, hold_full_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic [1:0]      skp_idx_q, skp_idx_d;
  logic [7:0]      sym_q, sym_d;
  logic            sym_is_k_q, sym_is_k_d;
  logic            sym_valid_q, sym_valid_d;
  logic            skp_active_q, skp_active_d;

  logic            boundary, skp_due, skp_service, ready, accept;
  logic [1:0]      next_byte;

  // State flags describe the symbol currently on sym_o; a boundary is an empty holder or byte 3 on the wire.
  assign boundary    = !hold_full_q || (byte_idx_q == BYTE_LAST);
  assign skp_service = en_i && (state_q == RUN) && boundary && skp_due;
  assign ready       = en_i && (state_q == RUN) && boundary && !skp_due;
  assign accept      = ready && mac.mac_data_frame_valid_i;
  assign next_byte   = byte_idx_q + 2'd1;

  skp_interval_timer #(
    .SKP_INTERVAL (SKP_INTERVAL),
    .CNT_W        (CNT_W)
  ) u_skp_timer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (!en_i),
    .tick_i    (state_q == RUN),
    .service_i (skp_service),
    .skp_due_o (skp_due)
  );

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    byte_idx_d   = byte_idx_q;
    skp_idx_d    = skp_idx_q;
    sym_d        = D0_0_IDLE;
    sym_is_k_d   = 1'b0;
    sym_valid_d  = 1'b0;
    skp_active_d = 1'b0;

    if (!en_i) begin
      state_d     = DISABLED;
      hold_d      = '0;
      hold_full_d = 1'b0;
      byte_idx_d  = '0;
      skp_idx_d   = '0;
    end else begin
      unique case (state_q)
        DISABLED: begin
          state_d     = RUN;
          sym_valid_d = 1'b1;
        end
        RUN: begin
          sym_valid_d = 1'b1;
          if (skp_service) begin
            state_d      = SKP;
            hold_full_d  = 1'b0;
            byte_idx_d   = '0;
            skp_idx_d    = '0;
            sym_d        = skp_os_symbol(2'd0);
            sym_is_k_d   = 1'b1;
            skp_active_d = 1'b1;
          end else if (accept) begin
            hold_d      = mac.mac_data_frame_i;
            hold_full_d = 1'b1;
            byte_idx_d  = '0;
            sym_d       = mac.mac_data_frame_i[7:0];
          end else if (boundary) begin
            hold_full_d = 1'b0;
            byte_idx_d  = '0;
          end else begin
            byte_idx_d = next_byte;
            sym_d      = hold_q[8*next_byte +: 8];
          end
        end
        SKP: begin
          sym_valid_d = 1'b1;
          if (skp_idx_q == SKP_LAST) begin
            state_d   = RUN;
            skp_idx_d = '0;
          end else begin
            skp_idx_d    = skp_idx_q + 2'd1;
            sym_d        = skp_os_symbol(skp_idx_q + 2'd1);
            sym_is_k_d   = 1'b1;
            skp_active_d = 1'b1;
          end
        end
        default: state_d = DISABLED;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= DISABLED;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      byte_idx_q   <= '0;
      skp_idx_q    <= '0;
      sym_q        <= D0_0_IDLE;
      sym_is_k_q   <= 1'b0;
      sym_valid_q  <= 1'b0;
      skp_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      byte_idx_q   <= byte_idx_d;
      skp_idx_q    <= skp_idx_d;
      sym_q        <= sym_d;
      sym_is_k_q   <= sym_is_k_d;
      sym_valid_q  <= sym_valid_d;
      skp_active_q <= skp_active_d;
    end
  end

  assign mac.mac_data_frame_ready_o = ready;
  assign mac.sym_o                  = sym_q;
  assign mac.sym_is_k_o             = sym_is_k_q;
  assign mac.sym_valid_o            = sym_valid_q;
  assign mac.skp_active_o           = skp_active_q;

endmodule

// File: tb/tb_tx_symbol_scheduler.sv
// Bench for tx_symbol_scheduler with SKP_INTERVAL=8: a queue-based symbol model checked
// every cycle, plus literal expectations for idle, single frame, streaming, disable and reset.
module tb_tx_symbol_scheduler;

  localparam int SKP_INT = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic en    = 1'b0;

  int tests_run    = 0;
  int tests_failed = 0;

  tx_symbol_scheduler_if mac_if ();

  tx_symbol_scheduler #(
    .MAC_FRAME_WIDTH (32),
    .SKP_INTERVAL    (SKP_INT)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .en_i   (en),
    .mac    (mac_if.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: mode 0 = off, 1 = data/idle, 2 = SKP set; m_bytes holds frame bytes still to go out.
  int         m_mode    = 0;
  int         m_skp_pos = 0;
  int         m_run_cnt = 0;
  bit         m_owed    = 0;
  logic [7:0] m_bytes[$];
  logic [7:0] m_sym     = 8'h00;
  bit         m_k = 0, m_valid = 0, m_act = 0;

  function automatic bit modelDue();
    return m_owed || (m_mode == 1 && ((m_run_cnt + 1) % SKP_INT) == 0);
  endfunction

  function automatic bit modelReady();
    return en && m_mode == 1 && m_bytes.size() == 0 && !modelDue();
  endfunction

  function automatic void modelReset();
    m_mode = 0; m_skp_pos = 0; m_run_cnt = 0; m_owed = 0;
    m_bytes.delete();
    m_sym = 8'h00; m_k = 0; m_valid = 0; m_act = 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || !en) begin
      modelReset();
    end else if (m_mode == 0) begin
      m_mode = 1; m_run_cnt = 0;
      m_sym = 8'h00; m_k = 0; m_valid = 1; m_act = 0;
    end else if (m_mode == 2) begin
      m_valid = 1;
      if (m_skp_pos == 3) begin
        m_mode = 1; m_sym = 8'h00; m_k = 0; m_act = 0;
      end else begin
        m_skp_pos++; m_sym = 8'h1C; m_k = 1; m_act = 1;
      end
    end else begin
      automatic bit due = modelDue();
      automatic bit rdy = modelReady();
      automatic logic [31:0] f = mac_if.mac_data_frame_i;
      m_run_cnt++;
      if ((m_run_cnt % SKP_INT) == 0) m_owed = 1;
      m_valid = 1; m_k = 0; m_act = 0;
      if (m_bytes.size() == 0 && due) begin
        m_mode = 2; m_skp_pos = 0; m_owed = 0;
        m_sym = 8'hBC; m_k = 1; m_act = 1;
      end else if (rdy && mac_if.mac_data_frame_valid_i) begin
        m_sym = f[7:0];
        m_bytes.push_back(f[15:8]);
        m_bytes.push_back(f[23:16]);
        m_bytes.push_back(f[31:24]);
      end else if (m_bytes.size() == 0) begin
        m_sym = 8'h00;
      end else begin
        m_sym = m_bytes.pop_front();
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("model sym", {24'h0, mac_if.sym_o}, {24'h0, m_sym});
      checkOutput("model is_k", {31'h0, mac_if.sym_is_k_o}, {31'h0, m_k});
      checkOutput("model valid", {31'h0, mac_if.sym_valid_o}, {31'h0, m_valid});
      checkOutput("model skp_active", {31'h0, mac_if.skp_active_o}, {31'h0, m_act});
      checkOutput("model ready", {31'h0, mac_if.mac_data_frame_ready_o}, {31'h0, modelReady()});
    end
  end

  logic [7:0] cap_sym[32];
  logic       cap_k[32], cap_v[32], cap_a[32];

  task automatic captureSymbols(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cap_sym[i] = mac_if.sym_o;
      cap_k[i]   = mac_if.sym_is_k_o;
      cap_v[i]   = mac_if.sym_valid_o;
      cap_a[i]   = mac_if.skp_active_o;
    end
  endtask

  task automatic applyStimulus(input logic [31:0] frame);
    bit taken = 0;
    bit rdy   = 0;
    mac_if.mac_data_frame_i       = frame;
    mac_if.mac_data_frame_valid_i = 1'b1;
    for (int c = 0; c < 50 && !taken; c++) begin
      @(negedge clk);
      rdy = mac_if.mac_data_frame_ready_o;
      @(posedge clk);
      taken = rdy;
    end
    #1;
    mac_if.mac_data_frame_valid_i = 1'b0;
    if (!taken) checkOutput("handshake timeout", 32'd0, 32'd1);
  endtask

  task automatic restartLink();
    @(posedge clk); #1 en = 1'b0;
    @(posedge clk); #1 en = 1'b1;
  endtask

  task automatic checkSkpSet(input int base, input string tag);
    checkOutput({tag, " COM"}, {24'h0, cap_sym[base]}, 32'hBC);
    checkOutput({tag, " COM is_k"}, {31'h0, cap_k[base]}, 32'd1);
    checkOutput({tag, " COM active"}, {31'h0, cap_a[base]}, 32'd1);
    for (int i = 1; i < 4; i++) begin
      checkOutput($sformatf("%s SKP%0d", tag, i), {24'h0, cap_sym[base+i]}, 32'h1C);
      checkOutput($sformatf("%s SKP%0d is_k", tag, i), {31'h0, cap_k[base+i]}, 32'd1);
    end
  endtask

  initial begin
    mac_if.mac_data_frame_i       = 32'h0;
    mac_if.mac_data_frame_valid_i = 1'b0;
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset valid", {31'h0, mac_if.sym_valid_o}, 32'd0);
    checkOutput("reset ready", {31'h0, mac_if.mac_data_frame_ready_o}, 32'd0);
    checkOutput("reset sym", {24'h0, mac_if.sym_o}, 32'd0);

    // Idle link: 8 idle symbols, then a full SKP set, then idle again.
    @(posedge clk); #1 en = 1'b1;
    @(posedge clk);
    captureSymbols(13);
    checkOutput("enable first valid", {31'h0, cap_v[0]}, 32'd1);
    checkOutput("enable first is_k", {31'h0, cap_k[0]}, 32'd0);
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("idle sym %0d", i), {24'h0, cap_sym[i]}, 32'h00);
    checkSkpSet(8, "idle skp");
    checkOutput("idle after skp", {24'h0, cap_sym[12]}, 32'h00);
    checkOutput("idle after skp active", {31'h0, cap_a[12]}, 32'd0);

    // Single frame right after a fresh enable.
    restartLink();
    applyStimulus(32'hDDCCBBAA);
    captureSymbols(5);
    checkOutput("single byte0", {24'h0, cap_sym[0]}, 32'hAA);
    checkOutput("single byte1", {24'h0, cap_sym[1]}, 32'hBB);
    checkOutput("single byte2", {24'h0, cap_sym[2]}, 32'hCC);
    checkOutput("single byte3", {24'h0, cap_sym[3]}, 32'hDD);
    checkOutput("single tail idle", {24'h0, cap_sym[4]}, 32'h00);

    // Back-to-back frames across an SKP insertion.
    restartLink();
    fork
      begin
        applyStimulus(32'h03020100);
        applyStimulus(32'h07060504);
        applyStimulus(32'h0B0A0908);
      end
      begin
        @(posedge clk);
        captureSymbols(16);
      end
    join
    for (int i = 1; i <= 8; i++)
      checkOutput($sformatf("stream byte %0d", i - 1), {24'h0, cap_sym[i]}, 32'(i - 1));
    checkSkpSet(9, "stream skp");
    checkOutput("stream post-skp idle", {24'h0, cap_sym[13]}, 32'h00);
    checkOutput("stream resume byte0", {24'h0, cap_sym[14]}, 32'h08);
    checkOutput("stream resume byte1", {24'h0, cap_sym[15]}, 32'h09);

    // Disable while byte1 is on the wire; remaining bytes and the counter are dropped.
    restartLink();
    applyStimulus(32'h44332211);
    @(negedge clk);
    checkOutput("disable byte0", {24'h0, mac_if.sym_o}, 32'h11);
    @(posedge clk); #1 en = 1'b0;
    @(negedge clk);
    checkOutput("disable byte1", {24'h0, mac_if.sym_o}, 32'h22);
    @(negedge clk);
    checkOutput("disabled valid", {31'h0, mac_if.sym_valid_o}, 32'd0);
    @(posedge clk); #1 en = 1'b1;
    @(posedge clk);
    captureSymbols(10);
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("reenable idle %0d", i), {24'h0, cap_sym[i]}, 32'h00);
    checkOutput("reenable valid", {31'h0, cap_v[0]}, 32'd1);
    checkOutput("reenable counter restart", {24'h0, cap_sym[8]}, 32'hBC);

    // Asynchronous reset away from any clock edge.
    fork
      applyStimulus(32'h5A5A5A5A);
    join_none
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset valid", {31'h0, mac_if.sym_valid_o}, 32'd0);
    checkOutput("async reset sym", {24'h0, mac_if.sym_o}, 32'd0);
    checkOutput("async reset ready", {31'h0, mac_if.mac_data_frame_ready_o}, 32'd0);
    disable fork;
    mac_if.mac_data_frame_valid_i = 1'b0;
    en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
